regfile_sb: RTL and testbench

Parametrised, clocked RISC-V integer register file with a per-register scoreboard. It replaces the strobe-driven two-read/one-write register bank and generalises it to NREAD read ports and NWRITE write ports. It adds write-to-read bypass, a hardwired-zero x0 and a pending bit per register. It sits between decode (reads, reservations) and writeback (writes) in the core pipeline.

---
 rtl/regfile_pkg.sv | 12 +
 rtl/regfile_rport.sv | 35 +++
 rtl/regfile_sb.sv | 101 ++++++++++
 tb/tb_regfile_sb.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and types for the scoreboarded register file.
package regfile_pkg;

   localparam int XLEN_DEF  = 32;
   localparam int NREGS_DEF = 32;
   localparam int AW_DEF    = $clog2(NREGS_DEF);

   typedef logic [AW_DEF-1:0] reg_idx_t;

   localparam reg_idx_t REG_ZERO = '0;

endpackage

// File: rtl/regfile_rport.sv
// One read port: picks the newest same-cycle write as bypass and forces x0 to zero.
module regfile_rport
   import regfile_pkg::*;
#(
   parameter int XLEN   = XLEN_DEF,
   parameter int AW     = AW_DEF,
   parameter int NWRITE = 2
) (
   input  logic [AW-1:0]                  addr,
   input  logic [XLEN-1:0]                stored_data,
   input  logic                           stored_pend,
   input  logic [NWRITE-1:0]              wr_en,
   input  logic [NWRITE-1:0][AW-1:0]      wr_addr,
   input  logic [NWRITE-1:0][XLEN-1:0]    wr_data,
   output logic [XLEN-1:0]                data,
   output logic                           busy
);

   always_comb begin
      data = stored_data;
      busy = stored_pend;
      // Ascending scan so the highest-index matching write is the one that sticks.
      for (int k = 0; k < NWRITE; k++) begin
         if (wr_en[k] && (wr_addr[k] == addr)) begin
            data = wr_data[k];
            busy = 1'b0;
         end
      end
      if (addr == AW'(REG_ZERO)) begin
         data = '0;
         busy = 1'b0;
      end
   end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port RISC-V integer register file with write bypass and a per-register pending bit.
module regfile_sb
   import regfile_pkg::*;
#(
   parameter int XLEN   = XLEN_DEF,
   parameter int NREGS  = NREGS_DEF,
   parameter int NREAD  = 2,
   parameter int NWRITE = 2,
   localparam int AW    = $clog2(NREGS)
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           rd_en,
   input  logic [NREAD-1:0][AW-1:0]       rs_addr,
   output logic [NREAD-1:0][XLEN-1:0]     rs_data,
   output logic [NREAD-1:0]               rs_busy,
   input  logic [NWRITE-1:0]              wr_en,
   input  logic [NWRITE-1:0][AW-1:0]      wr_addr,
   input  logic [NWRITE-1:0][XLEN-1:0]    wr_data,
   input  logic                           rsv_en,
   input  logic [AW-1:0]                  rsv_addr
);

   logic [XLEN-1:0]              regs_reg [NREGS];
   logic [NREGS-1:0]             pend_reg;
   logic [NREGS-1:0]             pend_next;
   logic [NREAD-1:0][XLEN-1:0]   rs_data_reg;
   logic [NREAD-1:0][XLEN-1:0]   rs_data_next;
   logic [NREAD-1:0]             rs_busy_reg;
   logic [NREAD-1:0]             rs_busy_next;

   // Reservation is applied after the write clears, so a same-cycle reserve wins.
   always_comb begin
      pend_next = pend_reg;
      for (int k = 0; k < NWRITE; k++) begin
         if (wr_en[k]) begin
            pend_next[wr_addr[k]] = 1'b0;
         end
      end
      if (rsv_en) begin
         pend_next[rsv_addr] = 1'b1;
      end
      pend_next[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pend_reg <= '0;
      end else begin
         pend_reg <= pend_next;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NREGS; gi++) begin : g_reg
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               regs_reg[gi] <= '0;
            end else if (gi != 0) begin
               for (int k = 0; k < NWRITE; k++) begin
                  if (wr_en[k] && (wr_addr[k] == AW'(gi))) begin
                     regs_reg[gi] <= wr_data[k];
                  end
               end
            end
         end
      end

      for (gi = 0; gi < NREAD; gi++) begin : g_rport
         regfile_rport #(
            .XLEN   (XLEN),
            .AW     (AW),
            .NWRITE (NWRITE)
         ) u_rport (
            .addr        (rs_addr[gi]),
            .stored_data (regs_reg[rs_addr[gi]]),
            .stored_pend (pend_reg[rs_addr[gi]]),
            .wr_en       (wr_en),
            .wr_addr     (wr_addr),
            .wr_data     (wr_data),
            .data        (rs_data_next[gi]),
            .busy        (rs_busy_next[gi])
         );
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rs_data_reg <= '0;
         rs_busy_reg <= '0;
      end else if (rd_en) begin
         rs_data_reg <= rs_data_next;
         rs_busy_reg <= rs_busy_next;
      end
   end

   assign rs_data = rs_data_reg;
   assign rs_busy = rs_busy_reg;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: expectations queued at drive time, checked after the edge.
module tb_regfile_sb;

   localparam int XLEN   = 32;
   localparam int NREGS  = 32;
   localparam int NREAD  = 2;
   localparam int NWRITE = 2;
   localparam int AW     = 5;

   logic                           clk;
   logic                           rst_n;
   logic                           rd_en;
   logic [NREAD-1:0][AW-1:0]       rs_addr;
   logic [NREAD-1:0][XLEN-1:0]     rs_data;
   logic [NREAD-1:0]               rs_busy;
   logic [NWRITE-1:0]              wr_en;
   logic [NWRITE-1:0][AW-1:0]      wr_addr;
   logic [NWRITE-1:0][XLEN-1:0]    wr_data;
   logic                           rsv_en;
   logic [AW-1:0]                  rsv_addr;

   typedef struct {
      string           tag;
      int              port;
      logic [XLEN-1:0] data;
      logic            busy;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks;
   int   n_fails;

   regfile_sb #(
      .XLEN   (XLEN),
      .NREGS  (NREGS),
      .NREAD  (NREAD),
      .NWRITE (NWRITE)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .rd_en    (rd_en),
      .rs_addr  (rs_addr),
      .rs_data  (rs_data),
      .rs_busy  (rs_busy),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .rsv_en   (rsv_en),
      .rsv_addr (rsv_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic idle();
      rd_en    = 1'b0;
      rs_addr  = '0;
      wr_en    = '0;
      wr_addr  = '0;
      wr_data  = '0;
      rsv_en   = 1'b0;
      rsv_addr = '0;
   endtask

   task automatic push(input string tag, input int port, input logic [XLEN-1:0] data, input logic busy);
      exp_t e;
      e.tag  = tag;
      e.port = port;
      e.data = data;
      e.busy = busy;
      exp_q.push_back(e);
   endtask

   task automatic rd(input int port, input int addr);
      rd_en         = 1'b1;
      rs_addr[port] = AW'(addr);
   endtask

   task automatic wr(input int port, input int addr, input logic [XLEN-1:0] data);
      wr_en[port]   = 1'b1;
      wr_addr[port] = AW'(addr);
      wr_data[port] = data;
   endtask

   task automatic rsv(input int addr);
      rsv_en   = 1'b1;
      rsv_addr = AW'(addr);
   endtask

   // Advance one edge, then check everything queued for it and clear the inputs.
   task automatic tick();
      exp_t e;
      @(posedge clk);
      #1;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_checks++;
         assert (rs_data[e.port] === e.data) else begin
            n_fails++;
            $error("FAIL %s data port%0d: got %h expected %h", e.tag, e.port, rs_data[e.port], e.data);
         end
         n_checks++;
         assert (rs_busy[e.port] === e.busy) else begin
            n_fails++;
            $error("FAIL %s busy port%0d: got %b expected %b", e.tag, e.port, rs_busy[e.port], e.busy);
         end
         $display("check %s port%0d data=%h busy=%b", e.tag, e.port, rs_data[e.port], rs_busy[e.port]);
      end
      idle();
   endtask

   initial begin
      n_checks = 0;
      n_fails  = 0;
      idle();
      rst_n = 1'b0;
      tick();
      push("reset_state", 0, 32'h0, 1'b0);
      push("reset_state", 1, 32'h0, 1'b0);
      tick();
      rst_n = 1'b1;

      // Fill the file with random data and reservations, then reset for two cycles.
      for (int i = 1; i < NREGS; i += 2) begin
         wr(0, i, $urandom());
         wr(1, (i + 1) % NREGS, $urandom());
         rsv(i);
         rd(0, i);
         rd(1, i);
         tick();
      end
      rst_n = 1'b0;
      wr(0, 6, 32'hFFFF_FFFF);
      rsv(6);
      tick();
      push("reset_out", 0, 32'h0, 1'b0);
      push("reset_out", 1, 32'h0, 1'b0);
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < NREGS; i += 2) begin
         rd(0, i);
         rd(1, i + 1);
         push("post_reset", 0, 32'h0, 1'b0);
         push("post_reset", 1, 32'h0, 1'b0);
         tick();
      end

      // Basic write then read.
      wr(0, 5, 32'hDEAD_BEEF);
      tick();
      rd(0, 5);
      rd(1, 0);
      push("basic_x5", 0, 32'hDEAD_BEEF, 1'b0);
      push("basic_x0", 1, 32'h0, 1'b0);
      tick();

      // x0 ignores writes, reservations and bypass.
      wr(1, 0, 32'h0000_1234);
      rsv(0);
      tick();
      rd(0, 0);
      rd(1, 0);
      wr(0, 0, 32'h0000_1234);
      push("x0_read", 0, 32'h0, 1'b0);
      push("x0_read", 1, 32'h0, 1'b0);
      tick();

      // Same-cycle writes on both ports plus bypassed reads.
      wr(0, 7, 32'h11);
      wr(1, 7, 32'h22);
      rd(0, 7);
      rd(1, 7);
      push("bypass_prio", 0, 32'h22, 1'b0);
      push("bypass_prio", 1, 32'h22, 1'b0);
      tick();
      rd(0, 7);
      rd(1, 5);
      push("stored_prio", 0, 32'h22, 1'b0);
      push("stored_x5", 1, 32'hDEAD_BEEF, 1'b0);
      tick();

      // Scoreboard: reserve, write-clears, reserve-and-write.
      rsv(3);
      rd(0, 3);
      push("rsv_not_yet", 0, 32'h0, 1'b0);
      push("rsv_not_yet", 1, 32'h0, 1'b0);
      tick();
      rd(0, 3);
      rd(1, 3);
      push("rsv_busy", 0, 32'h0, 1'b1);
      push("rsv_busy", 1, 32'h0, 1'b1);
      tick();
      wr(1, 3, 32'h55);
      rd(0, 3);
      push("wr_clears", 0, 32'h55, 1'b0);
      push("wr_clears_x0", 1, 32'h0, 1'b0);
      tick();
      rsv(3);
      wr(0, 3, 32'h66);
      rd(1, 3);
      push("rsv_wr_same_x0", 0, 32'h0, 1'b0);
      push("rsv_wr_same", 1, 32'h66, 1'b0);
      tick();
      rd(0, 3);
      rd(1, 7);
      push("rsv_wr_after", 0, 32'h66, 1'b1);
      push("rsv_wr_other", 1, 32'h22, 1'b0);
      tick();

      // Hold: outputs freeze while rd_en is low.
      wr(0, 9, 32'hA5A5_A5A5);
      tick();
      rd(0, 9);
      rd(1, 5);
      push("hold_setup", 0, 32'hA5A5_A5A5, 1'b0);
      push("hold_setup", 1, 32'hDEAD_BEEF, 1'b0);
      tick();
      wr(1, 9, 32'h0);
      rs_addr[0] = AW'(9);
      rs_addr[1] = AW'(3);
      push("hold1", 0, 32'hA5A5_A5A5, 1'b0);
      push("hold1", 1, 32'hDEAD_BEEF, 1'b0);
      tick();
      rs_addr[0] = AW'(9);
      push("hold2", 0, 32'hA5A5_A5A5, 1'b0);
      tick();
      rd(0, 9);
      push("hold_release", 0, 32'h0, 1'b0);
      tick();

      // Reset mid-operation discards same-cycle reserve and write.
      rst_n = 1'b0;
      rsv(4);
      wr(0, 4, 32'h77);
      rd(0, 4);
      rd(1, 9);
      push("mid_reset", 0, 32'h0, 1'b0);
      push("mid_reset", 1, 32'h0, 1'b0);
      tick();
      rst_n = 1'b1;
      rd(0, 4);
      rd(1, 7);
      push("after_mid_reset_x4", 0, 32'h0, 1'b0);
      push("after_mid_reset_x7", 1, 32'h0, 1'b0);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
